shift_iter_ctrl: RTL and testbench
==================================

Name: shift_iter_ctrl

Overview:
- Iterative sequencer wrapped around the existing 4-bit combinational right-shift/rotate stage (amount 0-3, rotate or fill mode).
- Accepts one operand word with a total shift count of 0-15, then drives the stage once per clock with a step of at most 3.
- Registers the stage output back into its accumulator on each step, and presents the final word on a valid/ready output.
- Sits directly upstream of the shifter as its operand/control source, and directly downstream as the consumer of its result.

Parameters:
- WIDTH, 4, data width; must equal the shifter stage width.
- CNT_W, 4, width of the total shift count.
- MAX_STEP, 3, largest amount the shifter stage accepts in one pass.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand word.
- in_count  input  CNT_W  total right-shift amount.
- in_rotate  input  1  1 = rotate, 0 = fill.
- in_fill  input  1  fill bit used in fill mode.
- shf_data_o  output  WIDTH  to shifter data input.
- shf_amt_o  output  2  to shifter amount select.
- shf_rotate_o  output  1  to shifter mode select.
- shf_fill_o  output  1  to shifter fill bit.
- shf_result_i  input  WIDTH  shifter output, combinational from shf_*_o.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  result word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Shifter contract: result[i] = data[i+amt] when i+amt < WIDTH. Otherwise result[i] = data[i+amt-WIDTH] if rotate, else fill.
- Reset (synchronous, active-high): state=IDLE; acc=0; rem=0; mode and fill regs = 0.
  - Output reset values: in_ready=1, out_valid=0, out_data=0, busy=0, shf_amt_o=0, shf_data_o=0, shf_rotate_o=0, shf_fill_o=0.
- shf_data_o=acc, shf_rotate_o=mode reg, shf_fill_o=fill reg at all times. shf_amt_o=0 outside RUN.
- IDLE:
  - in_ready=1.
  - On in_valid: acc<=in_data, rem<=in_count, latch rotate and fill.
  - Next state is DONE if in_count==0, else RUN.
- RUN:
  - step=min(rem, MAX_STEP); shf_amt_o=step; acc<=shf_result_i; rem<=rem-step.
  - When rem<=MAX_STEP, go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1, out_data=acc; both held stable until out_ready.
  - On out_ready: go to IDLE; in_ready rises the next cycle.
  - No same-cycle accept of a new operand.
- out_data is 0 whenever out_valid=0.
- Latency from accept edge to out_valid high: 1 + ceil(count/3) cycles.
  - count 0 -> 1 cycle; count 15 -> 6 cycles.
- Count arithmetic is unsigned; rem never underflows.
- Rotate with count >= WIDTH wraps naturally through iteration; no modulo reduction.
- in_valid while not IDLE is ignored; in_data is not sampled.
- rst asserted in any state (including mid-RUN or DONE with out_ready high) wins: returns to reset values next edge, result discarded.

Optional Feature:
- Macro: SHIFT_ITER_FASTFILL_EN.
- Defined: accept in fill mode with in_count >= WIDTH loads acc with {WIDTH{in_fill}} and goes directly to DONE. Latency is 1 cycle, and shf_amt_o stays 0.
- Undefined: normal iteration (e.g. count 15 takes 5 RUN cycles). Final out_data is identical either way; only latency and shifter activity differ.

Decomposition:
- Shared package shift_pkg holds:
  - constants SHF_WIDTH=4, SHF_MAX_STEP=3, SHF_CNT_W=4;
  - state enum typedef shift_iter_state_t {IDLE, RUN, DONE};
  - mode encoding constants SHF_MODE_FILL=0, SHF_MODE_ROT=1.
- No sub-module in RTL; the shifter stage is instantiated beside this block by the integrator.
- The bench instantiates the real shifter stage on shf_* to close the loop.

Test Plan:
- Rotate, count 5, in_data 4'b1001: steps 3 then 2, intermediate acc 4'b0011. out_data=4'b1100, out_valid 3 cycles after accept.
- Fill mode, fill=0, count 2, in_data 4'b1011: one RUN cycle with shf_amt_o=2. out_data=4'b0010, out_valid 2 cycles after accept.
- Fill, fill=1, count 6, in_data 4'b1011: out_data=4'b1111.
  - Without macro: 2 RUN cycles.
  - With SHIFT_ITER_FASTFILL_EN: 0 RUN cycles, shf_amt_o never nonzero.
- Count 0, in_data 4'b0110: out_valid exactly 1 cycle after accept with 4'b0110.
  - Then hold out_ready=0 for 4 cycles: out_valid and out_data stable.
  - Assert out_ready: in_ready=1 the following cycle.
- Rotate, count 15, in_data 4'b0001: shf_amt_o sequence 3,3,3,3,3; out_data=4'b0010.
  - in_valid pulses during RUN are ignored.
- Reset mid-RUN (count 9, rst on second RUN cycle): next cycle in IDLE with all outputs at reset values. A following count-1 rotate of 4'b1000 yields 4'b0100.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift sequencer and its 4-bit shifter stage.
package shift_pkg;

  localparam int SHF_WIDTH    = 4;
  localparam int SHF_MAX_STEP = 3;
  localparam int SHF_CNT_W    = 4;

  // Shifter mode select encoding
  localparam logic SHF_MODE_FILL = 1'b0;
  localparam logic SHF_MODE_ROT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } shift_iter_state_t;

endpackage

// File: rtl/shift_iter_ctrl.sv
// shift_iter_ctrl: iterative sequencer around a 4-bit right-shift/rotate stage.
// Takes one operand plus a 0-15 shift count, drives the external stage once per
// clock with a step of at most MAX_STEP, folds the result back into the
// accumulator and offers the final word on a valid/ready port.
// Optional build macro SHIFT_ITER_FASTFILL_EN: a fill-mode operand whose count
// reaches WIDTH is resolved at accept time (all fill bits), skipping the stage.
module shift_iter_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH    = SHF_WIDTH,
  parameter int CNT_W    = SHF_CNT_W,
  parameter int MAX_STEP = SHF_MAX_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_rotate,
  input  logic             in_fill,
  output logic [WIDTH-1:0] shf_data_o,
  output logic [1:0]       shf_amt_o,
  output logic             shf_rotate_o,
  output logic             shf_fill_o,
  input  logic [WIDTH-1:0] shf_result_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  shift_iter_state_t state;
  logic [WIDTH-1:0]  acc;
  logic [CNT_W-1:0]  rem;
  logic              rot_q;
  logic              fill_q;

  logic [1:0]        step;
  logic              last_step;
  logic              fast_fill;
  logic [WIDTH-1:0]  load_data;

  // Step size for this pass and whether it finishes the count
  always_comb begin
    step      = 2'd0;
    last_step = 1'b0;
    if (rem > CNT_W'(MAX_STEP)) begin
      step = 2'(MAX_STEP);
    end else begin
      step      = rem[1:0];
      last_step = 1'b1;
    end
  end

  // Accept-time shortcut: a fill shift by WIDTH or more leaves only fill bits
  always_comb begin
`ifdef SHIFT_ITER_FASTFILL_EN
    fast_fill = (in_rotate == SHF_MODE_FILL) && (in_count >= CNT_W'(WIDTH));
`else
    fast_fill = 1'b0;
`endif
    load_data = fast_fill ? {WIDTH{in_fill}} : in_data;
  end

  assign shf_data_o   = acc;
  assign shf_rotate_o = rot_q;
  assign shf_fill_o   = fill_q;
  assign shf_amt_o    = (state == RUN) ? step : 2'd0;

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      rem       <= '0;
      rot_q     <= 1'b0;
      fill_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= load_data;
            rem      <= fast_fill ? '0 : in_count;
            rot_q    <= in_rotate;
            fill_q   <= in_fill;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (fast_fill || in_count == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= load_data;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= shf_result_i;
          rem <= rem - CNT_W'(step);
          if (last_step) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= shf_result_i;
          end
        end
        DONE: begin
          // New operands are only taken once back in IDLE
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_data  <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_iter_ctrl.sv
// Directed bench for shift_iter_ctrl; a behavioural 4-bit shifter stage closes
// the loop on the shf_* port. Expected latencies follow SHIFT_ITER_FASTFILL_EN.
module tb_shift_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] in_count;
  logic       in_rotate;
  logic       in_fill;
  logic [3:0] shf_data_o;
  logic [1:0] shf_amt_o;
  logic       shf_rotate_o;
  logic       shf_fill_o;
  logic [3:0] shf_result_i;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_iter_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_count     (in_count),
    .in_rotate    (in_rotate),
    .in_fill      (in_fill),
    .shf_data_o   (shf_data_o),
    .shf_amt_o    (shf_amt_o),
    .shf_rotate_o (shf_rotate_o),
    .shf_fill_o   (shf_fill_o),
    .shf_result_i (shf_result_i),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  // Shifter stage: result[i] = data[i+amt], wrapping or filling past the top
  always_comb begin
    shf_result_i = '0;
    for (int i = 0; i < 4; i++) begin
      if (i + int'(shf_amt_o) < 4)
        shf_result_i[i] = shf_data_o[i + int'(shf_amt_o)];
      else
        shf_result_i[i] = shf_rotate_o ? shf_data_o[i + int'(shf_amt_o) - 4] : shf_fill_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),     32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid),    32'd0);
    chk({tag, ".out_data"},  32'(out_data),     32'd0);
    chk({tag, ".busy"},      32'(busy),         32'd0);
    chk({tag, ".amt"},       32'(shf_amt_o),    32'd0);
    chk({tag, ".sdata"},     32'(shf_data_o),   32'd0);
    chk({tag, ".srot"},      32'(shf_rotate_o), 32'd0);
    chk({tag, ".sfill"},     32'(shf_fill_o),   32'd0);
  endtask

  // Offer one operand at a negedge, then watch until out_valid (bounded).
  // lat counts edges from the accept edge inclusive; amt/data logs collect
  // the shifter controls seen on each RUN cycle, oldest in the high bits.
  task automatic run_op(input logic [3:0] d, input logic [3:0] cnt, input logic rot,
                        input logic fil, input bit poke,
                        output int lat, output int runs,
                        output logic [31:0] amt_log, output logic [31:0] dat_log);
    lat = 0; runs = 0; amt_log = '0; dat_log = '0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_count = cnt; in_rotate = rot; in_fill = fil;
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = 4'hF; in_count = 4'h0; in_rotate = 1'b0; in_fill = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      runs++;
      amt_log = {amt_log[29:0], shf_amt_o};
      dat_log = {dat_log[27:0], shf_data_o};
      if (poke) begin
        in_valid = 1'b1; in_data = 4'hA; in_count = 4'h1; in_rotate = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  // Release the result and confirm the block is back to IDLE
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"},  32'(out_data),  32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    int lat, runs;
    logic [31:0] al, dl;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0;
    in_rotate = 1'b0; in_fill = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("reset");

    // Rotate 1001 by 5: steps 3 then 2, middle value 0011
    run_op(4'b1001, 4'd5, 1'b1, 1'b0, 1'b0, lat, runs, al, dl);
    chk("rot5.lat",  32'(lat),  32'd3);
    chk("rot5.amts", al,        32'hE);
    chk("rot5.accs", dl,        32'h93);
    chk("rot5.data", 32'(out_data), 32'hC);
    chk("rot5.busy", 32'(busy), 32'd1);
    drain("rot5");

    // Fill 0, count 2 on 1011
    run_op(4'b1011, 4'd2, 1'b0, 1'b0, 1'b0, lat, runs, al, dl);
    chk("fill2.lat",  32'(lat), 32'd2);
    chk("fill2.amts", al,       32'h2);
    chk("fill2.data", 32'(out_data), 32'h2);
    drain("fill2");

    // Fill 1, count 6 on 1011
    run_op(4'b1011, 4'd6, 1'b0, 1'b1, 1'b0, lat, runs, al, dl);
`ifdef SHIFT_ITER_FASTFILL_EN
    chk("fill6.runs", 32'(runs), 32'd0);
    chk("fill6.lat",  32'(lat),  32'd1);
    chk("fill6.amt",  32'(shf_amt_o), 32'd0);
`else
    chk("fill6.runs", 32'(runs), 32'd2);
    chk("fill6.lat",  32'(lat),  32'd3);
    chk("fill6.amts", al,        32'hF);
`endif
    chk("fill6.data", 32'(out_data), 32'hF);
    drain("fill6");

    // Count 0: one-cycle latency, then held under back-pressure
    run_op(4'b0110, 4'd0, 1'b1, 1'b0, 1'b0, lat, runs, al, dl);
    chk("cnt0.lat",  32'(lat), 32'd1);
    chk("cnt0.data", 32'(out_data), 32'h6);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cnt0.hold_valid", 32'(out_valid), 32'd1);
      chk("cnt0.hold_data",  32'(out_data),  32'h6);
      chk("cnt0.hold_rdy",   32'(in_ready),  32'd0);
    end
    drain("cnt0");

    // Rotate 0001 by 15 with in_valid poked throughout RUN
    run_op(4'b0001, 4'd15, 1'b1, 1'b0, 1'b1, lat, runs, al, dl);
    chk("rot15.lat",  32'(lat), 32'd6);
    chk("rot15.amts", al,       32'h3FF);
    chk("rot15.data", 32'(out_data), 32'h2);
    drain("rot15");

    // Reset on the second RUN cycle of a count-9 operation
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1011; in_count = 4'd9; in_rotate = 1'b1; in_fill = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rst9.run1_amt", 32'(shf_amt_o), 32'd3);
    @(negedge clk);
    chk("rst9.run2_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst9");

    run_op(4'b1000, 4'd1, 1'b1, 1'b0, 1'b0, lat, runs, al, dl);
    chk("post.lat",  32'(lat), 32'd2);
    chk("post.data", 32'(out_data), 32'h4);
    drain("post");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
